// File: rtl/uart_rx_param.sv
// uart_rx_param -- oversampling UART receiver with configurable frame format
// and a small receive FIFO.
//
// The serial line is synchronised, then each bit is decided by a 3-sample
// majority vote around mid-bit. Frames carry 5..8 data bits (LSB first),
// optional even/odd parity and 1 or 2 stop bits. Completed words are pushed
// with their parity/frame flags into a FIFO that downstream logic drains
// with a valid/ready handshake. An all-zero frame with a low stop bit is
// reported as a break instead of a word.
//
// Ports:
//   RX_clk          receiver clock, all state updates on the rising edge
//   rst             asynchronous active-low reset
//   input_signal    serial line, idle high, asynchronous to RX_clk
//   snum            stop bits: 0 = one, 1 = two
//   dnum            data bits: 00 = 5, 01 = 6, 10 = 7, 11 = 8
//   par             parity: 01 = even, 10 = odd, 00/11 = none
//   data            FIFO head word, right-justified, unused upper bits 0
//   data_valid      FIFO non-empty; data and flags valid
//   data_ready      consumer accepts the head word when high with data_valid
//   parity_warning  head word had a parity mismatch
//   frame_warning   head word had a stop bit sampled 0
//   break_detect    one-cycle pulse on a break condition
//   overrun         one-cycle pulse when a completed word is dropped
//   fifo_count      number of words held
module uart_rx_param #(
  parameter int OVS   = 16,
  parameter int DEPTH = 4
) (
  input  logic                   RX_clk,
  input  logic                   rst,
  input  logic                   input_signal,
  input  logic                   snum,
  input  logic [1:0]             dnum,
  input  logic [1:0]             par,
  output logic [7:0]             data,
  output logic                   data_valid,
  input  logic                   data_ready,
  output logic                   parity_warning,
  output logic                   frame_warning,
  output logic                   break_detect,
  output logic                   overrun,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(OVS);

  localparam logic [TW-1:0] T_S0     = TW'(OVS / 2 - 1);
  localparam logic [TW-1:0] T_S1     = TW'(OVS / 2);
  localparam logic [TW-1:0] T_MID    = TW'(OVS / 2 + 1);
  localparam logic [TW-1:0] T_LAST   = TW'(OVS - 1);
  localparam logic [TW-1:0] TICK_ONE = TW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP1  = 3'd4;
  localparam logic [2:0] STOP2  = 3'd5;
  localparam logic [2:0] BREAK  = 3'd6;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Even: data ^ parity must be 0; odd: must be 1.
  function automatic logic parity_bad(input logic [7:0] d, input logic p, input logic odd);
    return (^d) ^ p ^ odd;
  endfunction

  logic          meta_r, rx_s;
  logic [2:0]    state_r;
  logic [TW-1:0] tick_r;
  logic [2:0]    bit_idx_r;
  logic [7:0]    shift_r;
  logic          s0_r, s1_r;
  logic          snum_q, pbit_r, pflag_r, fflag_r;
  logic [1:0]    dnum_q, par_q;

  logic          mid_s, wrap_s, maj_s, par_en_s, last_bit_s, brk_s;
  logic          push_s, frame_s;
  logic [TW-1:0] tick_inc_s;
  logic [9:0]    word_s;

  logic [9:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r, rd_ptr_r, rd_nxt_s;
  logic [AW:0]   count_r, count_nxt_s;
  logic          pop_s, full_s, wr_en_s;

  // Two-flop synchroniser for the asynchronous serial line.
  always_ff @(posedge RX_clk or negedge rst) begin
    if (!rst) begin
      meta_r <= 1'b1;
      rx_s   <= 1'b1;
    end else begin
      meta_r <= input_signal;
      rx_s   <= meta_r;
    end
  end

  // Mid-bit decision, break detection and word assembly at frame end.
  always_comb begin
    mid_s      = (tick_r == T_MID);
    wrap_s     = (tick_r == T_LAST);
    tick_inc_s = wrap_s ? '0 : tick_r + TICK_ONE;
    maj_s      = maj3(s0_r, s1_r, rx_s);
    par_en_s   = (par_q == 2'b01) || (par_q == 2'b10);
    last_bit_s = (bit_idx_r == (3'd4 + {1'b0, dnum_q}));
    brk_s      = (shift_r == 8'h00) && (!par_en_s || !pbit_r) && !maj_s;
    frame_s    = ~maj_s;
    if (mid_s && (state_r == STOP1) && !snum_q && !brk_s) begin
      push_s = 1'b1;
    end else if (mid_s && (state_r == STOP2)) begin
      push_s  = 1'b1;
      frame_s = fflag_r | ~maj_s;
    end else begin
      push_s = 1'b0;
    end
    word_s = {shift_r, pflag_r, frame_s};
  end

  // Receive FSM: bit timing, sampling and per-frame flag collection.
  always_ff @(posedge RX_clk or negedge rst) begin
    if (!rst) begin
      state_r      <= IDLE;
      tick_r       <= '0;
      bit_idx_r    <= 3'd0;
      shift_r      <= 8'h00;
      s0_r         <= 1'b1;
      s1_r         <= 1'b1;
      snum_q       <= 1'b0;
      dnum_q       <= 2'b00;
      par_q        <= 2'b00;
      pbit_r       <= 1'b0;
      pflag_r      <= 1'b0;
      fflag_r      <= 1'b0;
      break_detect <= 1'b0;
    end else begin
      break_detect <= 1'b0;
      if (tick_r == T_S0) s0_r <= rx_s;
      if (tick_r == T_S1) s1_r <= rx_s;
      case (state_r)
        IDLE: begin
          // The cycle that first sees the low line is tick 0 of the start bit.
          if (!rx_s) begin
            state_r   <= START;
            tick_r    <= TICK_ONE;
            snum_q    <= snum;
            dnum_q    <= dnum;
            par_q     <= par;
            bit_idx_r <= 3'd0;
            shift_r   <= 8'h00;
            pbit_r    <= 1'b0;
            pflag_r   <= 1'b0;
            fflag_r   <= 1'b0;
          end else begin
            tick_r <= '0;
          end
        end
        START: begin
          tick_r <= tick_inc_s;
          if (mid_s && maj_s) begin
            state_r <= IDLE;
            tick_r  <= '0;
          end else if (wrap_s) begin
            state_r <= DATA;
          end
        end
        DATA: begin
          tick_r <= tick_inc_s;
          if (mid_s) shift_r[bit_idx_r] <= maj_s;
          if (wrap_s) begin
            if (last_bit_s) state_r <= par_en_s ? PARITY : STOP1;
            else            bit_idx_r <= bit_idx_r + 3'd1;
          end
        end
        PARITY: begin
          tick_r <= tick_inc_s;
          if (mid_s) begin
            pbit_r  <= maj_s;
            pflag_r <= parity_bad(shift_r, maj_s, par_q == 2'b10);
          end
          if (wrap_s) state_r <= STOP1;
        end
        STOP1: begin
          tick_r <= tick_inc_s;
          if (mid_s) begin
            if (brk_s) begin
              state_r      <= BREAK;
              tick_r       <= '0;
              break_detect <= 1'b1;
            end else if (!snum_q) begin
              state_r <= IDLE;
              tick_r  <= '0;
            end else begin
              fflag_r <= ~maj_s;
            end
          end else if (wrap_s) begin
            state_r <= STOP2;
          end
        end
        STOP2: begin
          tick_r <= tick_inc_s;
          if (mid_s) begin
            state_r <= IDLE;
            tick_r  <= '0;
          end
        end
        BREAK: begin
          // Leave only after OVS consecutive high samples.
          if (rx_s) begin
            if (wrap_s) begin
              state_r <= IDLE;
              tick_r  <= '0;
            end else begin
              tick_r <= tick_r + TICK_ONE;
            end
          end else begin
            tick_r <= '0;
          end
        end
        default: begin
          state_r <= IDLE;
          tick_r  <= '0;
        end
      endcase
    end
  end

  // FIFO control: a push into a full FIFO succeeds only with a same-cycle pop.
  always_comb begin
    pop_s    = data_valid & data_ready;
    full_s   = (count_r == CNT_FULL);
    wr_en_s  = push_s & (~full_s | pop_s);
    rd_nxt_s = rd_ptr_r + PTR_ONE;
    if (wr_en_s && !pop_s) begin
      count_nxt_s = count_r + CNT_ONE;
    end else if (!wr_en_s && pop_s) begin
      count_nxt_s = count_r - CNT_ONE;
    end else begin
      count_nxt_s = count_r;
    end
  end

  // FIFO storage array (contents are don't-care until written).
  always_ff @(posedge RX_clk) begin
    if (wr_en_s) mem_r[wr_ptr_r] <= word_s;
  end

  // FIFO pointers, count, overrun pulse and registered head word.
  always_ff @(posedge RX_clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r       <= '0;
      rd_ptr_r       <= '0;
      count_r        <= '0;
      data_valid     <= 1'b0;
      overrun        <= 1'b0;
      data           <= 8'h00;
      parity_warning <= 1'b0;
      frame_warning  <= 1'b0;
    end else begin
      overrun    <= push_s & full_s & ~pop_s;
      count_r    <= count_nxt_s;
      data_valid <= (count_nxt_s != '0);
      if (wr_en_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_s)   rd_ptr_r <= rd_nxt_s;
      // Head follows the next stored word on pop, or the new word when
      // the FIFO is (or becomes) empty at the same moment it is written.
      if (pop_s) begin
        if (count_r > CNT_ONE) begin
          {data, parity_warning, frame_warning} <= mem_r[rd_nxt_s];
        end else if (wr_en_s) begin
          {data, parity_warning, frame_warning} <= word_s;
        end
      end else if (wr_en_s && (count_r == '0)) begin
        {data, parity_warning, frame_warning} <= word_s;
      end
    end
  end

  assign fifo_count = count_r;

endmodule

// File: tb/tb_uart_rx_param.sv
module tb_uart_rx_param;

  localparam int OVS   = 16;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       input_signal = 1'b1;
  logic       snum = 1'b0;
  logic [1:0] dnum = 2'b00;
  logic [1:0] par = 2'b00;
  logic       data_ready = 1'b0;
  logic [7:0] data;
  logic       data_valid, parity_warning, frame_warning, break_detect, overrun;
  logic [$clog2(DEPTH):0] fifo_count;

  int checks = 0, failures = 0, cyc = 0;
  int brk_seen = 0, brk_exp = 0, ovr_seen = 0, ovr_exp = 0;
  int start_cyc = 0, rise_cyc = -1;
  logic prev_valid = 1'b0;
  logic [9:0] exp_q[$];
  logic [9:0] mon_w;

  always #5 clk = ~clk;

  uart_rx_param #(.OVS(OVS), .DEPTH(DEPTH)) dut (
    .RX_clk(clk), .rst(rst), .input_signal(input_signal),
    .snum(snum), .dnum(dnum), .par(par),
    .data(data), .data_valid(data_valid), .data_ready(data_ready),
    .parity_warning(parity_warning), .frame_warning(frame_warning),
    .break_detect(break_detect), .overrun(overrun), .fifo_count(fifo_count)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: pulse counting and scoreboard comparison on every accepted word.
  always @(negedge clk) begin
    if (break_detect === 1'b1) brk_seen++;
    if (overrun === 1'b1) ovr_seen++;
    if (data_valid === 1'b1 && prev_valid !== 1'b1) rise_cyc = cyc;
    prev_valid = data_valid;
    if (rst && data_valid && data_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", 32'(data), 32'hFFFF_FFFF);
      end else begin
        mon_w = exp_q.pop_front();
        check("word_data", 32'(data), 32'(mon_w[9:2]));
        check("word_parity_flag", 32'(parity_warning), 32'(mon_w[1]));
        check("word_frame_flag", 32'(frame_warning), 32'(mon_w[0]));
      end
    end
  end

  task automatic drive_bit(input logic b);
    input_signal = b;
    repeat (OVS) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    input_signal = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model: expected word computed from the frame definition.
  task automatic send_frame(input logic [7:0] d, input logic [1:0] dn, input logic [1:0] pr,
                            input logic sn, input logic perr, input logic s1e, input logic s2e);
    int n;
    logic [7:0] m;
    logic pen, pbit, brk;
    n    = 5 + int'(dn);
    m    = d & 8'((1 << n) - 1);
    pen  = (pr == 2'b01) || (pr == 2'b10);
    pbit = (^m) ^ (pr == 2'b10) ^ perr;
    brk  = (m == 8'h00) && (!pen || !pbit) && s1e;
    if (brk) brk_exp++;
    else if (exp_q.size() >= DEPTH) ovr_exp++;
    else exp_q.push_back({m, pen & perr, s1e | (sn & s2e)});
    snum = sn; dnum = dn; par = pr;
    start_cyc = cyc;
    drive_bit(1'b0);
    // Configuration changes mid-frame must be ignored.
    snum = 1'($urandom_range(1)); dnum = 2'($urandom_range(3)); par = 2'($urandom_range(3));
    for (int i = 0; i < n; i++) drive_bit(m[i]);
    if (pen) drive_bit(pbit);
    drive_bit(~s1e);
    if (sn) drive_bit(~s2e);
    input_signal = 1'b1;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_data"}, 32'(data), 32'd0);
    check({tag, "_valid"}, 32'(data_valid), 32'd0);
    check({tag, "_pw"}, 32'(parity_warning), 32'd0);
    check({tag, "_fw"}, 32'(frame_warning), 32'd0);
    check({tag, "_brk"}, 32'(break_detect), 32'd0);
    check({tag, "_ovr"}, 32'(overrun), 32'd0);
    check({tag, "_count"}, 32'(fifo_count), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic sn, s1e, s2e, perr;
    logic [1:0] dn, pr;
    logic [7:0] d;

    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst = 1'b1;
    idle(OVS);

    // 8N1 0xA5: latency and head contents with the consumer stalled.
    data_ready = 1'b0;
    rise_cyc = -1;
    send_frame(8'hA5, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    check("latency_8n1", 32'(rise_cyc - start_cyc), 32'd156);
    check("a5_data", 32'(data), 32'hA5);
    check("a5_pw", 32'(parity_warning), 32'd0);
    check("a5_fw", 32'(frame_warning), 32'd0);
    check("a5_count", 32'(fifo_count), 32'd1);
    data_ready = 1'b1;
    idle(4);
    check("a5_pop_count", 32'(fifo_count), 32'd0);
    idle(OVS);

    // 7E2 0x55 with inverted parity bit; 5N1 0x1F; 8N1 0x3C with low stop bit.
    send_frame(8'h55, 2'b10, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(OVS);
    check("7e2_pw_head", 32'(parity_warning), 32'd1);
    send_frame(8'h1F, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(OVS);
    check("5n1_data_head", 32'(data), 32'h1F);
    send_frame(8'h3C, 2'b11, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(2 * OVS);
    check("3c_fw_head", 32'(frame_warning), 32'd1);

    // Break: line low for 12 bit times, then recover after OVS high cycles.
    snum = 1'b0; dnum = 2'b11; par = 2'b00;
    brk_exp++;
    input_signal = 1'b0;
    repeat (12 * OVS) @(posedge clk);
    #1;
    idle(OVS + 2);
    check("break_pulses", 32'(brk_seen), 32'(brk_exp));
    check("break_no_push", 32'(fifo_count), 32'd0);
    send_frame(8'h5A, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(OVS);

    // Glitch rejection: 1-cycle and 6-cycle low pulses.
    input_signal = 1'b0;
    @(posedge clk); #1;
    idle(2 * OVS);
    input_signal = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    idle(2 * OVS);
    check("glitch_no_push", 32'(fifo_count), 32'd0);
    send_frame(8'h96, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(OVS);
    drain("drain_directed");

    // Overrun: DEPTH+1 back-to-back frames with the consumer stalled.
    data_ready = 1'b0;
    for (int i = 0; i <= DEPTH; i++)
      send_frame(8'($urandom_range(255)), 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(OVS);
    check("overrun_count_full", 32'(fifo_count), 32'(DEPTH));
    check("overrun_pulses", 32'(ovr_seen), 32'(ovr_exp));
    data_ready = 1'b1;
    drain("drain_overrun");
    idle(OVS);

    // Randomised frames against the reference model.
    for (int k = 0; k < 16; k++) begin
      dn   = 2'($urandom_range(3));
      pr   = 2'($urandom_range(3));
      sn   = 1'($urandom_range(1));
      perr = ($urandom_range(3) == 0);
      s1e  = ($urandom_range(7) == 0);
      s2e  = ($urandom_range(7) == 0);
      d    = ($urandom_range(3) == 0) ? 8'h00 : 8'($urandom_range(255));
      send_frame(d, dn, pr, sn, perr, s1e, s2e);
      if (s1e || (sn && s2e)) idle(2 * OVS);
      else idle($urandom_range(OVS));
    end
    idle(OVS);
    drain("drain_random");

    // Reset mid-DATA of 0x81 while a flagged word sits in the FIFO.
    data_ready = 1'b0;
    send_frame(8'h6B, 2'b11, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(OVS);
    check("pre_reset_valid", 32'(data_valid), 32'd1);
    snum = 1'b0; dnum = 2'b11; par = 2'b00;
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    input_signal = 1'b0;
    repeat (OVS / 2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("midframe_reset");
    input_signal = 1'b1;
    rst = 1'b1;
    idle(3 * OVS);
    check("post_reset_count", 32'(fifo_count), 32'd0);
    data_ready = 1'b1;
    send_frame(8'h42, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(OVS);
    drain("drain_after_reset");

    check("break_total", 32'(brk_seen), 32'(brk_exp));
    check("overrun_total", 32'(ovr_seen), 32'(ovr_exp));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised, oversampling UART receiver for the serial front end of the pipe-line design; next generation of the fixed-format receiver. Recovers 5–8 data bits, optional even/odd parity and 1 or 2 stop bits from `input_signal`, using a synchroniser and 3-sample majority vote at mid-bit. Detects break conditions and buffers received words with their error flags in a small FIFO. Downstream logic drains the FIFO through a valid/ready handshake.

## Interface
- `OVS`, 16: clock cycles per bit (oversampling factor, even, ≥8)
- `DEPTH`, 4: receive FIFO depth in words (power of 2, ≥2)
- `RX_clk`  in  1  receiver clock; all state updates on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `input_signal`  in  1  serial line, idle high, asynchronous to `RX_clk`
- `snum`  in  1  stop bits: 0 = one, 1 = two
- `dnum`  in  2  data bits: 00 = 5, 01 = 6, 10 = 7, 11 = 8
- `par`  in  2  parity: 00 = none, 01 = even, 10 = odd, 11 = none
- `data`  out  8  FIFO head word, LSB-first reassembled, right-justified, unused upper bits 0
- `data_valid`  out  1  FIFO non-empty; `data`/flags valid
- `data_ready`  in  1  consumer accepts head word when high with `data_valid`
- `parity_warning`  out  1  head word had parity mismatch
- `frame_warning`  out  1  head word had a stop bit sampled 0
- `break_detect`  out  1  one-cycle pulse on break
- `overrun`  out  1  one-cycle pulse when a completed word is dropped because FIFO is full
- `fifo_count`  out  $clog2(DEPTH)+1  words held

## Operation
- `input_signal` passes a 2-flop synchroniser (output `rx_s`, reset to 1); all logic uses `rx_s`.
- Bit sample = majority of `rx_s` at tick counts OVS/2-1, OVS/2, OVS/2+1 of the bit (tick counter 0..OVS-1).
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2, BREAK.
- IDLE: on `rx_s` = 0, latch `snum`/`dnum`/`par` and go to START with tick = 0. Configuration changes mid-frame have no effect.
- START: majority at mid-bit = 1 -> false start, back to IDLE, nothing pushed. Otherwise go to DATA at tick wrap.
- DATA: shift sample into bit position 0..N-1 (LSB first). After N bits go to PARITY if `par` is 01/10, else STOP1.
- PARITY: even requires XOR(data, parity bit) = 0; odd requires 1; mismatch sets the word's parity flag.
- STOP1: a sample of 0 sets the word's frame flag. With `snum` = 1 go to STOP2 at tick wrap, else finish.
- STOP2: same check; finish.
- Finish happens immediately after the mid-bit sample of the last stop bit, so the receiver can resync to the next start edge.
- Break rule: data = 0, the parity sample (if present) = 0 and the first stop sample = 0:
  - no push; pulse `break_detect`; enter BREAK;
  - BREAK returns to IDLE only after `rx_s` = 1 for OVS consecutive cycles.
- Push at finish: word {data, parity flag, frame flag}.
  - If FIFO is full and no pop happens that cycle: word is dropped, `overrun` pulses, FIFO contents unchanged.
  - Push and pop in the same cycle when full: both occur and count is unchanged.
- Pop: `data_valid` & `data_ready`. Pointers wrap modulo DEPTH.
- Reset (any time, including mid-frame): FSM -> IDLE; FIFO empties; partial frame discarded.
- Reset values: `data` = 0, `data_valid` = 0, `parity_warning` = 0, `frame_warning` = 0, `break_detect` = 0, `overrun` = 0, `fifo_count` = 0.

## Timing
- One bit = OVS cycles. Mid-bit decision occurs at tick OVS/2+1.
- Frame latency: `data_valid` rises (if FIFO was empty) on the cycle after the last stop-bit decision.
  - Referenced to the `input_signal` falling edge: 2 (synchroniser) + (1+N+P+S-1)·OVS + OVS/2+1 + 1 cycles.
  - P = parity bits (0/1), S = stop bits.
  - 8N1 at OVS = 16: 2+144+9+1 = 156 cycles.
- `data`, `parity_warning`, `frame_warning` are registered FIFO-head outputs and change only on push-to-empty or pop.
- `break_detect` and `overrun` are high for exactly one cycle.
- Back-to-back frames with no idle gap are received without loss.

## Test plan
- 8N1 (`dnum`=11, `par`=00, `snum`=0), send 0xA5 -> after 156 cycles `data`=0xA5, `data_valid`=1, both warnings 0; pop -> `fifo_count`=0.
- 7E2 sending 0x55 with a wrong parity bit (1) -> `data`=0x55, `parity_warning`=1, `frame_warning`=0; 5N1 sending 0x1F -> `data`=0x1F, upper bits 0.
- 8N1 0x3C with stop bit driven 0 -> `frame_warning`=1. Line held low for 12 bit times -> single `break_detect` pulse, no push; recovery after OVS high cycles.
- 1-cycle low glitch on idle line, then 6-cycle low pulse -> no push, FSM back in IDLE; next valid frame received correctly.
- `data_ready`=0, send DEPTH+1 frames -> `fifo_count`=DEPTH, one `overrun` pulse, first DEPTH words popped in order afterwards.
- Assert `rst` low mid-DATA of frame 0x81 -> outputs at reset values, nothing pushed; a following frame 0x42 is received correctly.
